// File: rtl/hazard_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : hazard_sequencer
// Brief    : RAW-hazard stall, taken-branch flush and memory-busy freeze
//            controller for the 5-stage pipeline. Optional macro
//            HAZARD_PERF_CNT_EN adds saturating stall/flush counters.
// Revision : 1.0
// ============================================================================
module hazard_sequencer #(
   parameter int REG_AW = 3,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REG_AW-1:0] src1,
   input  logic [REG_AW-1:0] src2,
   input  logic              src2_used,
   input  logic [REG_AW-1:0] dest_exe,
   input  logic              wb_en_exe,
   input  logic              mem_read_exe,
   input  logic [REG_AW-1:0] dest_mem,
   input  logic              wb_en_mem,
   input  logic              forwarding_en,
   input  logic              branch_taken,
   input  logic              mem_busy,
   output logic              pc_hold,
   output logic              ifid_hold,
   output logic              idexe_bubble,
   output logic              ifid_flush,
   output logic              freeze,
   output logic [CNT_W-1:0]  stall_count,
   output logic [CNT_W-1:0]  flush_count
);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_STALL = 1'b1
   } state_t;

   state_t     r_state;
   logic [1:0] r_rem;

   logic       w_match_exe;
   logic       w_match_mem;
   logic [1:0] w_need;
   logic       w_freeze;
   logic       w_flush;
   logic       w_stall;

   // r0 is hardwired to zero, so a write to it can never create a dependency
   assign w_match_exe = wb_en_exe && (dest_exe != '0) &&
                        ((dest_exe == src1) || (src2_used && (dest_exe == src2)));
   assign w_match_mem = wb_en_mem && (dest_mem != '0) &&
                        ((dest_mem == src1) || (src2_used && (dest_mem == src2)));

   always_comb begin
      w_need = 2'd0;
      if (forwarding_en) begin
         if (w_match_exe && mem_read_exe)
            w_need = 2'd1;
      end else if (w_match_exe) begin
         w_need = 2'd2;
      end else if (w_match_mem) begin
         w_need = 2'd1;
      end
   end

   assign w_freeze = rst_n & mem_busy;
   assign w_flush  = rst_n & ~mem_busy & branch_taken;
   assign w_stall  = rst_n & ~mem_busy & ~branch_taken &
                     ((r_state == ST_STALL) || (w_need != 2'd0));

   assign freeze       = w_freeze;
   assign ifid_flush   = w_flush;
   assign pc_hold      = w_stall;
   assign ifid_hold    = w_stall;
   assign idexe_bubble = w_stall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_rem   <= 2'd0;
      end else if (mem_busy) begin
         r_state <= r_state;
         r_rem   <= r_rem;
      end else if (branch_taken) begin
         // the stalled instruction is squashed, so its pending stall goes too
         r_state <= ST_IDLE;
         r_rem   <= 2'd0;
      end else if (r_state == ST_STALL) begin
         if (r_rem <= 2'd1) begin
            r_state <= ST_IDLE;
            r_rem   <= 2'd0;
         end else begin
            r_rem   <= r_rem - 2'd1;
         end
      end else if (w_need != 2'd0) begin
         r_rem <= w_need - 2'd1;
         if (w_need == 2'd2)
            r_state <= ST_STALL;
         else
            r_state <= ST_IDLE;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_stall && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if (w_flush && (r_flush_cnt != '1))
            r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
   end

   assign stall_count = r_stall_cnt;
   assign flush_count = r_flush_cnt;
`else
   assign stall_count = '0;
   assign flush_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_sequencer
// Brief    : Directed scoreboard bench for hazard_sequencer (default and
//            HAZARD_PERF_CNT_EN builds).
// Revision : 1.0
// ============================================================================
module tb_hazard_sequencer;

   localparam int REG_AW = 3;
   localparam int CNT_W  = 16;

   localparam logic [4:0] c_none  = 5'b00000;
   localparam logic [4:0] c_stall = 5'b11100;
   localparam logic [4:0] c_flush = 5'b00010;
   localparam logic [4:0] c_frz   = 5'b00001;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [REG_AW-1:0] src1, src2, dest_exe, dest_mem;
   logic              src2_used, wb_en_exe, mem_read_exe, wb_en_mem;
   logic              forwarding_en, branch_taken, mem_busy;
   logic              pc_hold, ifid_hold, idexe_bubble, ifid_flush, freeze;
   logic [CNT_W-1:0]  stall_count, flush_count;

   logic [4:0]        sb_q[$];
   logic [CNT_W-1:0]  exp_sc = '0;
   logic [CNT_W-1:0]  exp_fc = '0;
   int                total = 0;
   int                bad   = 0;

   always #5 clk = ~clk;

   hazard_sequencer #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .src1         (src1),
      .src2         (src2),
      .src2_used    (src2_used),
      .dest_exe     (dest_exe),
      .wb_en_exe    (wb_en_exe),
      .mem_read_exe (mem_read_exe),
      .dest_mem     (dest_mem),
      .wb_en_mem    (wb_en_mem),
      .forwarding_en(forwarding_en),
      .branch_taken (branch_taken),
      .mem_busy     (mem_busy),
      .pc_hold      (pc_hold),
      .ifid_hold    (ifid_hold),
      .idexe_bubble (idexe_bubble),
      .ifid_flush   (ifid_flush),
      .freeze       (freeze),
      .stall_count  (stall_count),
      .flush_count  (flush_count)
   );

   task automatic clear_in();
      src1 = '0; src2 = '0; src2_used = 1'b0;
      dest_exe = '0; wb_en_exe = 1'b0; mem_read_exe = 1'b0;
      dest_mem = '0; wb_en_mem = 1'b0;
      forwarding_en = 1'b0; branch_taken = 1'b0; mem_busy = 1'b0;
   endtask

   // Pushes the expected output vector, checks it on the falling edge, then
   // advances to just after the next rising edge.
   task automatic cyc(input logic [4:0] exp, input string tag);
      logic [4:0] got;
      logic [4:0] want;
      sb_q.push_back(exp);
      @(negedge clk);
      got  = {pc_hold, ifid_hold, idexe_bubble, ifid_flush, freeze};
      want = sb_q.pop_front();
      total++;
      assert (got === want) else begin
         bad++;
         $error("FAIL %s outs got=%b want=%b", tag, got, want);
      end
      total++;
      assert (stall_count === exp_sc) else begin
         bad++;
         $error("FAIL %s stall_count got=%0d want=%0d", tag, stall_count, exp_sc);
      end
      total++;
      assert (flush_count === exp_fc) else begin
         bad++;
         $error("FAIL %s flush_count got=%0d want=%0d", tag, flush_count, exp_fc);
      end
`ifdef HAZARD_PERF_CNT_EN
      if (want[4] && exp_sc != '1) exp_sc = exp_sc + 1'b1;
      if (want[1] && exp_fc != '1) exp_fc = exp_fc + 1'b1;
`endif
      @(posedge clk);
      #1;
   endtask

   initial begin
      // reset: hazard, branch and busy all asserted, yet outputs must be 0
      rst_n = 1'b0;
      clear_in();
      dest_exe = 3'd5; wb_en_exe = 1'b1; src1 = 3'd5;
      cyc(c_none, "rst_hazard");
      branch_taken = 1'b1; mem_busy = 1'b1;
      cyc(c_none, "rst_br_busy");
      rst_n = 1'b1;
      clear_in();
      cyc(c_none, "idle");

      // forwarding on, load-use: one bubble
      forwarding_en = 1'b1; dest_exe = 3'd3; wb_en_exe = 1'b1; mem_read_exe = 1'b1; src1 = 3'd3;
      cyc(c_stall, "ld_use");
      wb_en_exe = 1'b0; mem_read_exe = 1'b0; dest_mem = 3'd3; wb_en_mem = 1'b1;
      cyc(c_none, "ld_use_rel");
      clear_in();
      forwarding_en = 1'b1; dest_exe = 3'd3; wb_en_exe = 1'b1; src1 = 3'd3;
      cyc(c_none, "fwd_alu");

      // no forwarding, EXE hit on src2: two stall cycles
      clear_in();
      dest_exe = 3'd5; wb_en_exe = 1'b1; src1 = 3'd1; src2 = 3'd5; src2_used = 1'b1;
      cyc(c_stall, "exe_s2_c1");
      wb_en_exe = 1'b0; dest_mem = 3'd5; wb_en_mem = 1'b1;
      cyc(c_stall, "exe_s2_c2");
      clear_in();
      cyc(c_none, "exe_s2_rel");
      dest_exe = 3'd5; wb_en_exe = 1'b1; src1 = 3'd1; src2 = 3'd5; src2_used = 1'b0;
      cyc(c_none, "s2_unused");

      // r0 destination ignored, MEM hit gives one stall
      clear_in();
      dest_exe = 3'd0; wb_en_exe = 1'b1; dest_mem = 3'd2; wb_en_mem = 1'b1; src1 = 3'd2;
      cyc(c_stall, "mem_hit");
      clear_in();
      cyc(c_none, "mem_hit_rel");
      dest_exe = 3'd0; wb_en_exe = 1'b1; src1 = 3'd0;
      cyc(c_none, "r0_only");

      // branch in second stall cycle squashes the stall
      clear_in();
      dest_exe = 3'd5; wb_en_exe = 1'b1; src1 = 3'd5;
      cyc(c_stall, "br_c1");
      branch_taken = 1'b1;
      cyc(c_flush, "br_flush");
      clear_in();
      cyc(c_none, "br_idle");
      branch_taken = 1'b1;
      cyc(c_flush, "b2b_1");
      cyc(c_flush, "b2b_2");
      clear_in();
      cyc(c_none, "b2b_rel");

      // memory busy during STALL rem=1 freezes, then the stall resumes
      dest_exe = 3'd4; wb_en_exe = 1'b1; src1 = 3'd4;
      cyc(c_stall, "frz_c1");
      clear_in();
      mem_busy = 1'b1;
      cyc(c_frz, "frz_1");
      cyc(c_frz, "frz_2");
      cyc(c_frz, "frz_3");
      mem_busy = 1'b0;
      cyc(c_stall, "frz_resume");
      cyc(c_none, "frz_rel");

      // busy in IDLE suppresses detection; busy beats branch
      dest_exe = 3'd6; wb_en_exe = 1'b1; src2 = 3'd6; src2_used = 1'b1; mem_busy = 1'b1;
      cyc(c_frz, "busy_idle");
      branch_taken = 1'b1;
      cyc(c_frz, "busy_over_br");
      branch_taken = 1'b0; mem_busy = 1'b0;
      cyc(c_stall, "busy_det_c1");
      clear_in();
      cyc(c_stall, "busy_det_c2");
      cyc(c_none, "busy_det_rel");

      // forwarding enabled mid-stall: stall completes, next IDLE uses new mode
      dest_exe = 3'd7; wb_en_exe = 1'b1; src1 = 3'd7;
      cyc(c_stall, "fwdchg_c1");
      forwarding_en = 1'b1;
      cyc(c_stall, "fwdchg_c2");
      cyc(c_none, "fwdchg_idle");

`ifdef HAZARD_PERF_CNT_EN
      // continuous load-use hazard keeps pc_hold high every cycle in IDLE
      clear_in();
      forwarding_en = 1'b1; dest_exe = 3'd3; wb_en_exe = 1'b1; mem_read_exe = 1'b1; src1 = 3'd3;
      begin
         int n;
         n = 65535 - int'(exp_sc) + 2;
         repeat (n) @(posedge clk);
         #1;
         exp_sc = '1;
      end
      clear_in();
      cyc(c_none, "sat_hold");
      forwarding_en = 1'b1; dest_exe = 3'd3; wb_en_exe = 1'b1; mem_read_exe = 1'b1; src1 = 3'd3;
      cyc(c_stall, "sat_more");
      clear_in();
      cyc(c_none, "sat_final");
`endif

      // async reset mid-run clears counters
      rst_n = 1'b0;
      exp_sc = '0;
      exp_fc = '0;
      #1;
      total++;
      assert ((stall_count === '0) && (flush_count === '0)) else begin
         bad++;
         $error("FAIL async_rst counters got=%0d/%0d want=0/0", stall_count, flush_count);
      end
      rst_n = 1'b1;
      cyc(c_none, "post_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
